// File: rtl/hipage_pkg.sv
// Shared types and address constants for the CPU high-page responder.
package hipage_pkg;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

  typedef enum logic [1:0] {NONE, IO, HRAM, IE} region_t;

  localparam logic [15:0] HIPAGE_BASE = 16'hff00;
  localparam logic [15:0] HRAM_BASE   = 16'hff80;
  localparam logic [15:0] IE_ADR      = 16'hffff;

  // IE is checked first because $FFFF also falls inside the HRAM page.
  function automatic region_t classify(input logic [15:0] adr);
    if (adr == IE_ADR)
      return IE;
    else if (adr[15:7] == HRAM_BASE[15:7])
      return HRAM;
    else if (adr[15:7] == HIPAGE_BASE[15:7])
      return IO;
    else
      return NONE;
  endfunction

endpackage

// File: rtl/hipage_responder_hram.sv
// 127-byte high RAM with synchronous read and synchronous write.
module hram_127x8 (
  input  logic       clk,
  input  logic [6:0] adr,
  input  logic       we,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:126];

  // Offset 7'h7f belongs to IE, so it is never stored and reads as zero.
  always_ff @(posedge clk) begin
    if (we && (adr != 7'h7f))
      mem[adr] <= wdata;
    rdata <= (adr == 7'h7f) ? 8'h00 : mem[adr];
  end

endmodule

// File: rtl/hipage_responder.sv
// High-page ($FF00-$FFFF) bus responder: local HRAM and IE, I/O strobes for $FF00-$FF7F.
module hipage_responder
  import hipage_pkg::*;
#(
  parameter logic [7:0] IE_RESET = 8'h00,
  parameter logic [7:0] IE_MASK  = 8'hff
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        t1,
  input  logic [15:0] adr,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rdata_oe,
  output logic [6:0]  io_adr,
  output logic        io_rd,
  output logic        io_wr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata
);

  state_t  state, state_nxt;
  region_t region_in, region_q;
  logic       access_ok;
  logic       rd_q, wr_q;
  logic [6:0] adr_lo;
  logic [7:0] ie_q;
  logic [7:0] rd_buf;
  logic [7:0] hram_rdata;
  logic       commit;
  logic       hram_we;

  assign region_in = classify(adr);
  // A real access needs a mapped region and exactly one of rd/wr.
  assign access_ok = (region_in != NONE) && (rd != wr);

  // A write lands on the edge ending T3 unless a new M-cycle starts on that same edge.
  assign commit  = (state == T3) && wr_q && !t1;
  assign hram_we = commit && (region_q == HRAM);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // T-state sequencing; any t1 restarts the M-cycle, no-op accesses park in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      T1:      state_nxt = T2;
      T2:      state_nxt = T3;
      T3:      state_nxt = T4;
      T4:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (t1)
      state_nxt = access_ok ? T1 : IDLE;
  end

  // Latch the access attributes at the start of each real access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      region_q <= NONE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      adr_lo   <= 7'h00;
    end else if (t1 && access_ok) begin
      region_q <= region_in;
      rd_q     <= rd;
      wr_q     <= wr;
      adr_lo   <= adr[6:0];
    end
  end

  // Capture I/O or IE read data on the edge ending T2 so it is stable for T3/T4.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rd_buf <= 8'h00;
    else if ((state == T2) && rd_q)
      rd_buf <= (region_q == IO) ? io_rdata : (ie_q | ~IE_MASK);
  end

  // Commit IE and I/O write data on the edge ending T3.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ie_q     <= IE_RESET;
      io_wdata <= 8'h00;
    end else if (commit) begin
      if (region_q == IE)
        ie_q <= wdata & IE_MASK;
      if (region_q == IO)
        io_wdata <= wdata;
    end
  end

  hram_127x8 u_hram (
    .clk   (clk),
    .adr   (adr_lo),
    .we    (hram_we),
    .wdata (wdata),
    .rdata (hram_rdata)
  );

  assign io_adr   = adr_lo;
  assign io_rd    = (state == T2) && rd_q && (region_q == IO);
  assign io_wr    = (state == T4) && wr_q && (region_q == IO);
  assign rdata_oe = ((state == T3) || (state == T4)) && rd_q;
  assign rdata    = !rdata_oe          ? 8'h00 :
                    (region_q == HRAM) ? hram_rdata : rd_buf;

endmodule

// File: tb/tb_hipage_responder.sv
// Directed self-checking bench for hipage_responder (default and IE_MASK=8'h1f instances).
module tb_hipage_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        t1;
  logic [15:0] adr;
  logic        rd, wr;
  logic [7:0]  wdata;
  logic [7:0]  io_rdata;

  logic [7:0]  rdata, io_wdata;
  logic        rdata_oe, io_rd, io_wr;
  logic [6:0]  io_adr;

  logic [7:0]  m_rdata, m_io_wdata;
  logic        m_rdata_oe, m_io_rd, m_io_wr;
  logic [6:0]  m_io_adr;

  int check_count = 0;
  int error_count = 0;

  logic [3:0] oe_v, iord_v, iowr_v, m_oe_v, m_iord_v, m_iowr_v;
  logic [7:0] rdata_t3, rdata_t4, m_rdata_t3, iowdata_t4, m_iowdata_t4;
  logic [6:0] m_ioadr_t4;

  hipage_responder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .t1       (t1),
    .adr      (adr),
    .rd       (rd),
    .wr       (wr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rdata_oe (rdata_oe),
    .io_adr   (io_adr),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata)
  );

  hipage_responder #(.IE_RESET(8'h00), .IE_MASK(8'h1f)) dut_masked (
    .clk      (clk),
    .reset_n  (reset_n),
    .t1       (t1),
    .adr      (adr),
    .rd       (rd),
    .wr       (wr),
    .wdata    (wdata),
    .rdata    (m_rdata),
    .rdata_oe (m_rdata_oe),
    .io_adr   (m_io_adr),
    .io_rd    (m_io_rd),
    .io_wr    (m_io_wr),
    .io_wdata (m_io_wdata),
    .io_rdata (io_rdata)
  );

  // One T-state per clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: starts an M-cycle there and samples mid T1..T4 (bit i = T(i+1)).
  task automatic applyStimulus(input logic [15:0] a, input logic r, input logic w, input logic [7:0] d);
    t1 = 1'b1; adr = a; rd = r; wr = w; wdata = 8'h00;
    @(posedge clk);
    #1;
    t1 = 1'b0; adr = 16'h0000; rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      oe_v[i] = rdata_oe;   iord_v[i] = io_rd;   iowr_v[i] = io_wr;
      m_oe_v[i] = m_rdata_oe; m_iord_v[i] = m_io_rd; m_iowr_v[i] = m_io_wr;
      if (i == 2) begin
        rdata_t3   = rdata;
        m_rdata_t3 = m_rdata;
        wdata      = d;
        io_rdata   = ~io_rdata;
      end
      if (i == 3) begin
        rdata_t4     = rdata;
        iowdata_t4   = io_wdata;
        m_iowdata_t4 = m_io_wdata;
        m_ioadr_t4   = m_io_adr;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; t1 = 1'b0; adr = 16'h0000; rd = 1'b0; wr = 1'b0;
    wdata = 8'h00; io_rdata = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset rdata_oe", {31'd0, rdata_oe}, 32'd0);
    checkOutput("reset rdata",    {24'd0, rdata},    32'd0);
    checkOutput("reset io_strb",  {30'd0, io_rd, io_wr}, 32'd0);
    checkOutput("reset io_adr",   {25'd0, io_adr},   32'd0);
    checkOutput("reset io_wdata", {24'd0, io_wdata}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // IE after reset
    applyStimulus(16'hffff, 1'b1, 1'b0, 8'h00);
    checkOutput("ie reset read",        {24'd0, rdata_t3},   32'h00);
    checkOutput("ie reset read masked", {24'd0, m_rdata_t3}, 32'he0);

    // I/O read
    io_rdata = 8'h91;
    applyStimulus(16'hff44, 1'b1, 1'b0, 8'h00);
    checkOutput("io rd strobe",  {28'd0, iord_v}, 32'b0010);
    checkOutput("io rd oe",      {28'd0, oe_v},   32'b1100);
    checkOutput("io rd no wr",   {28'd0, iowr_v}, 32'b0000);
    checkOutput("io rd data t3", {24'd0, rdata_t3}, 32'h91);
    checkOutput("io rd data t4", {24'd0, rdata_t4}, 32'h91);
    checkOutput("io rd adr",     {25'd0, io_adr},   32'h44);
    checkOutput("io rd strobe masked", {28'd0, m_iord_v}, 32'b0010);

    // HRAM write/read, $FFFE unaffected
    applyStimulus(16'hfffe, 1'b0, 1'b1, 8'hc3);
    applyStimulus(16'hff80, 1'b0, 1'b1, 8'h5a);
    checkOutput("hram wr oe",  {28'd0, oe_v},   32'b0000);
    checkOutput("hram wr io",  {24'd0, iord_v, iowr_v}, 32'd0);
    applyStimulus(16'hff80, 1'b1, 1'b0, 8'h00);
    checkOutput("hram rd ff80 t3", {24'd0, rdata_t3}, 32'h5a);
    checkOutput("hram rd ff80 t4", {24'd0, rdata_t4}, 32'h5a);
    checkOutput("hram rd oe",      {28'd0, oe_v},     32'b1100);
    checkOutput("hram rd no io",   {28'd0, iord_v},   32'b0000);
    applyStimulus(16'hfffe, 1'b1, 1'b0, 8'h00);
    checkOutput("hram rd fffe", {24'd0, rdata_t3}, 32'hc3);

    // IE writes through both masks
    applyStimulus(16'hffff, 1'b0, 1'b1, 8'h1f);
    applyStimulus(16'hffff, 1'b1, 1'b0, 8'h00);
    checkOutput("ie 1f",        {24'd0, rdata_t3},   32'h1f);
    checkOutput("ie 1f masked", {24'd0, m_rdata_t3}, 32'hff);
    checkOutput("ie rd oe masked", {28'd0, m_oe_v},  32'b1100);
    applyStimulus(16'hffff, 1'b0, 1'b1, 8'hff);
    applyStimulus(16'hffff, 1'b1, 1'b0, 8'h00);
    checkOutput("ie ff",        {24'd0, rdata_t3},   32'hff);
    checkOutput("ie ff masked", {24'd0, m_rdata_t3}, 32'hff);
    applyStimulus(16'hffff, 1'b0, 1'b1, 8'h0a);
    applyStimulus(16'hffff, 1'b1, 1'b0, 8'h00);
    checkOutput("ie 0a",        {24'd0, rdata_t3},   32'h0a);
    checkOutput("ie 0a masked", {24'd0, m_rdata_t3}, 32'hea);

    // Out of range and malformed requests are silent no-ops
    applyStimulus(16'hc000, 1'b1, 1'b0, 8'h00);
    checkOutput("c000 rd quiet", {20'd0, oe_v, iord_v, iowr_v}, 32'd0);
    applyStimulus(16'hc000, 1'b0, 1'b1, 8'hee);
    checkOutput("c000 wr quiet", {20'd0, oe_v, iord_v, iowr_v}, 32'd0);
    applyStimulus(16'hfe9f, 1'b1, 1'b0, 8'h00);
    checkOutput("fe9f rd quiet", {20'd0, oe_v, iord_v, iowr_v}, 32'd0);
    applyStimulus(16'hfe9f, 1'b0, 1'b1, 8'hee);
    checkOutput("fe9f wr quiet", {20'd0, oe_v, iord_v, iowr_v}, 32'd0);
    applyStimulus(16'hff80, 1'b1, 1'b1, 8'hee);
    checkOutput("rd+wr quiet",   {20'd0, oe_v, iord_v, iowr_v}, 32'd0);
    applyStimulus(16'hff80, 1'b1, 1'b0, 8'h00);
    checkOutput("ff80 untouched", {24'd0, rdata_t3}, 32'h5a);
    applyStimulus(16'hffff, 1'b1, 1'b0, 8'h00);
    checkOutput("ie untouched",   {24'd0, rdata_t3}, 32'h0a);

    // I/O write
    applyStimulus(16'hff01, 1'b0, 1'b1, 8'h81);
    checkOutput("io wr strobe", {28'd0, iowr_v}, 32'b1000);
    checkOutput("io wr no rd",  {28'd0, iord_v | oe_v}, 32'b0000);
    checkOutput("io wr data",   {24'd0, iowdata_t4}, 32'h81);
    checkOutput("io wr adr",    {25'd0, io_adr},     32'h01);
    checkOutput("io wr masked", {17'd0, m_iowr_v, m_iowdata_t4, m_ioadr_t4}, {17'd0, 4'b1000, 8'h81, 7'h01});

    // Abort: t1 reasserted in T2 of a write to $FF90
    applyStimulus(16'hff90, 1'b0, 1'b1, 8'h11);
    t1 = 1'b1; adr = 16'hff90; rd = 1'b0; wr = 1'b1; wdata = 8'h77;
    @(posedge clk);
    #1;
    t1 = 1'b0; adr = 16'h0000; wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    applyStimulus(16'hff90, 1'b1, 1'b0, 8'h77);
    checkOutput("abort no commit", {24'd0, rdata_t3}, 32'h11);

    // Reset in T2 of a write to $FF90
    t1 = 1'b1; adr = 16'hff90; rd = 1'b0; wr = 1'b1; wdata = 8'h77;
    @(posedge clk);
    #1;
    t1 = 1'b0; adr = 16'h0000; wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre-reset io_adr", {25'd0, io_adr}, 32'h10);
    reset_n = 1'b0;
    #1;
    checkOutput("async reset io_adr",   {25'd0, io_adr},   32'h00);
    checkOutput("async reset io_wdata", {24'd0, io_wdata}, 32'h00);
    checkOutput("async reset outs",     {22'd0, rdata, rdata_oe, io_rd}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'hff90, 1'b1, 1'b0, 8'h00);
    checkOutput("reset no commit", {24'd0, rdata_t3}, 32'h11);
    applyStimulus(16'hffff, 1'b1, 1'b0, 8'h00);
    checkOutput("ie after reset",        {24'd0, rdata_t3},   32'h00);
    checkOutput("ie after reset masked", {24'd0, m_rdata_t3}, 32'he0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
